// File: rtl/latch_wr_pkg.sv
// Shared types and helpers for the latch write sequencer.
package latch_wr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/latch_wr_sequencer_if.sv
// Write-request handshake between a requester and the latch write sequencer.
interface latch_wr_sequencer_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [WIDTH-1:0]  req_data;

    modport master (output req_valid, output req_addr, output req_data, input req_ready);
    modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/latch_wr_timer.sv
// Loadable down-counter; stops at zero and flags terminal count.
module latch_wr_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/latch_wr_sequencer.sv
// Write controller for a bank of level-sensitive latch rows: drives D, then
// pulses one GATE with whole-cycle setup/pulse/hold around it.
//   state | meaning
//   IDLE  | ready for a request, lat_d holds last written value
//   SETUP | D driven, all gates low
//   PULSE | selected row gate high
//   HOLD  | gates low, D still held
module latch_wr_sequencer
    import latch_wr_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int ADDR_W       = 2,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 1,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    latch_wr_sequencer_if.slave   req,
    output logic [WIDTH-1:0]      lat_d,
    output logic [DEPTH-1:0]      lat_gate,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    if ((2 ** ADDR_W) < DEPTH) begin : g_chk_addr
        $error("latch_wr_sequencer: ADDR_W too narrow for DEPTH");
    end
    if ((SETUP_CYCLES < 1) || (PULSE_CYCLES < 1) || (HOLD_CYCLES < 1)) begin : g_chk_cycles
        $error("latch_wr_sequencer: SETUP/PULSE/HOLD_CYCLES must be >= 1");
    end

    localparam int TMAX = max3(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES);
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

    localparam logic [TW-1:0]     SETUP_LD = TW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0]     PULSE_LD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0]     HOLD_LD  = TW'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   row;
    logic [DEPTH-1:0]    row_hot;
    logic [DEPTH-1:0]    gate_nx;
    logic                done_nx;
    logic                err_nx;
    logic                accept;
    logic                addr_ok;
    logic                t_load;
    logic [TW-1:0]       t_val;
    logic                t_zero;

    latch_wr_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    assign req.req_ready = (state == IDLE);
    assign busy          = ~req.req_ready;
    assign addr_ok       = ({1'b0, req.req_addr} < DEPTH_V);

    always_comb begin
        row_hot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            row_hot[i] = (row == ADDR_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        t_load   = 1'b0;
        t_val    = '0;
        accept   = 1'b0;
        gate_nx  = lat_gate;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (req.req_valid && req.req_ready) begin
                    if (addr_ok) begin
                        accept   = 1'b1;
                        state_nx = SETUP;
                        t_load   = 1'b1;
                        t_val    = SETUP_LD;
                    end else begin
                        // Rejected request is consumed; nothing latch-facing moves.
                        err_nx = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (t_zero) begin
                    state_nx = PULSE;
                    gate_nx  = row_hot;
                    t_load   = 1'b1;
                    t_val    = PULSE_LD;
                end
            end
            PULSE: begin
                if (t_zero) begin
                    state_nx = HOLD;
                    gate_nx  = '0;
                    t_load   = 1'b1;
                    t_val    = HOLD_LD;
                end
            end
            HOLD: begin
                if (t_zero) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                gate_nx  = '0;
            end
        endcase
    end

    // Latch-facing outputs are all registered so the latches never see a glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_d    <= '0;
            lat_gate <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            row      <= '0;
        end else begin
            if (accept) begin
                lat_d <= req.req_data;
                row   <= req.req_addr;
            end
            lat_gate <= gate_nx;
            done     <= done_nx;
            err      <= err_nx;
        end
    end

endmodule
